pc_fetch_unit: RTL

//  PC register and instruction-fetch sequencer; the consumer of the next-PC value.

---
 rtl/pc_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding IMEM fetch sequencer with a decode handshake.
// Optional misaligned-next-PC trap is enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] fetch_cnt_o,
    output logic        misalign_o,
    output logic [31:0] epc_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        hs;
    logic        trap;

    assign hs = (state_q == HOLD) && inst_ready_i;

`ifdef MISALIGN_TRAP_EN
    logic        mis_q;
    logic [31:0] epc_q;

    assign trap = hs && (npc_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mis_q <= 1'b0;
            epc_q <= 32'h0;
        end else begin
            mis_q <= trap;
            if (trap) begin
                epc_q <= npc_i;
            end
        end
    end

    assign misalign_o = mis_q;
    assign epc_o      = epc_q;
`else
    assign trap       = 1'b0;
    assign misalign_o = 1'b0;
    assign epc_o      = 32'h0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready_i) begin
                    // Without the trap, low PC bits are simply dropped.
                    pc_d    = trap ? TRAP_VEC : (npc_i & ~32'h3);
                    cnt_d   = cnt_q + 32'd1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            cnt_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = (state_q == HOLD);
    assign fetch_cnt_o  = cnt_q;

endmodule
